// File: rtl/imm_field_encoder.sv
// Compresses a 64-bit immediate into the 26-bit instruction field for I/D/B/CB/MOV formats.
// Optional MOV halfword scan is built only when IMM_ENC_MOV_EN is defined.
module imm_field_encoder (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [2:0]  i_ctrl,
    input  logic [63:0] i_bus_imm,
    output logic [25:0] o_imm26,
    output logic        o_fits,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_err_count
);

    localparam int unsigned BUS_W  = 64;
    localparam int unsigned IMM_W  = 26;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned HW_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [BUS_W-1:0]   r_bus;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [IMM_W-1:0]   r_imm26;
    logic               r_fits;
    logic [ERR_W-1:0]   r_err_count;
    logic               w_accept;
    logic               w_load;
    logic [IMM_W-1:0]   w_imm_nxt;
    logic               w_fits_nxt;

`ifdef IMM_ENC_MOV_EN
    logic [1:0]         r_cnt;
    logic               r_found;
    logic               r_multi;
    logic [1:0]         r_idx;
    logic [HW_W-1:0]    r_val;
    logic [5:0]         w_base;
    logic [HW_W-1:0]    w_hw;
    logic               w_found_nxt;
    logic               w_multi_nxt;
    logic [1:0]         w_idx_nxt;
    logic [HW_W-1:0]    w_val_nxt;
`endif

    // True when v[63:msb] are all copies of v[msb], i.e. v is a valid sign extension.
    function automatic logic sext_fits(input logic [BUS_W-1:0] v, input logic [5:0] msb);
        logic [BUS_W-1:0] s;
        s = BUS_W'($signed(v) >>> msb);
        return (&s) | ~(|s);
    endfunction

    assign w_accept = (r_state == S_IDLE) && i_in_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
`ifdef IMM_ENC_MOV_EN
                    w_state_nxt = i_ctrl[2] ? S_SCAN : S_CHECK;
`else
                    w_state_nxt = S_CHECK;
`endif
                end
            end
            S_CHECK: w_state_nxt = S_DONE;
            S_SCAN: begin
`ifdef IMM_ENC_MOV_EN
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result formation; w_load marks the edge that enters DONE.
    always_comb begin
        w_load     = 1'b0;
        w_imm_nxt  = '0;
        w_fits_nxt = 1'b0;
`ifdef IMM_ENC_MOV_EN
        w_base      = {r_cnt, 4'b0000};
        w_hw        = r_bus[w_base +: HW_W];
        w_found_nxt = r_found;
        w_multi_nxt = r_multi;
        w_idx_nxt   = r_idx;
        w_val_nxt   = r_val;
`endif
        case (r_state)
            S_CHECK: begin
                w_load = 1'b1;
                if (!r_ctrl[2]) begin
                    case (r_ctrl[1:0])
                        2'b00: begin
                            w_imm_nxt[21:10] = r_bus[11:0];
                            w_fits_nxt       = sext_fits(r_bus, 6'd11);
                        end
                        2'b01: begin
                            w_imm_nxt[20:12] = r_bus[8:0];
                            w_fits_nxt       = sext_fits(r_bus, 6'd8);
                        end
                        2'b10: begin
                            w_imm_nxt  = r_bus[25:0];
                            w_fits_nxt = sext_fits(r_bus, 6'd25);
                        end
                        default: begin
                            w_imm_nxt[23:5] = r_bus[18:0];
                            w_fits_nxt      = sext_fits(r_bus, 6'd18);
                        end
                    endcase
                end
            end
`ifdef IMM_ENC_MOV_EN
            S_SCAN: begin
                if (w_hw != '0) begin
                    if (r_found) begin
                        w_multi_nxt = 1'b1;
                    end else begin
                        w_found_nxt = 1'b1;
                        w_idx_nxt   = r_cnt;
                        w_val_nxt   = w_hw;
                    end
                end
                if (r_cnt == 2'd3) begin
                    w_load     = 1'b1;
                    w_imm_nxt  = {3'b000, w_idx_nxt, w_val_nxt, 5'b00000};
                    w_fits_nxt = ~w_multi_nxt;
                end
            end
`endif
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl      <= '0;
            r_bus       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_imm26     <= '0;
            r_fits      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_ctrl <= i_ctrl;
                r_bus  <= i_bus_imm;
            end
            if (w_load) begin
                r_imm26     <= w_imm_nxt;
                r_fits      <= w_fits_nxt;
                r_out_valid <= 1'b1;
                if (!w_fits_nxt && (r_err_count != ERR_MAX)) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
            end else if ((r_state == S_DONE) && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef IMM_ENC_MOV_EN
    // Halfword scan bookkeeping, cleared on every accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_multi <= 1'b0;
            r_idx   <= '0;
            r_val   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_multi <= 1'b0;
            r_idx   <= '0;
            r_val   <= '0;
        end else if (r_state == S_SCAN) begin
            r_cnt   <= r_cnt + 2'd1;
            r_found <= w_found_nxt;
            r_multi <= w_multi_nxt;
            r_idx   <= w_idx_nxt;
            r_val   <= w_val_nxt;
        end
    end
`endif

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_imm26     = r_imm26;
    assign o_fits      = r_fits;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed plus randomized bench for imm_field_encoder against a range-based reference model.
module tb_imm_field_encoder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [2:0]  i_ctrl;
    logic [63:0] i_bus_imm;
    logic [25:0] o_imm26;
    logic        o_fits;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_err_count;

    int n_cmp = 0;
    int n_err = 0;
    int model_err = 0;

    imm_field_encoder dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_ctrl      (i_ctrl),
        .i_bus_imm   (i_bus_imm),
        .o_imm26     (o_imm26),
        .o_fits      (o_fits),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_err_count (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a field fits when the signed value lies inside the field's two's-complement range.
    task automatic ref_enc(input logic [2:0] c, input logic [63:0] b,
                           output logic [25:0] imm, output logic f, output int lat);
        longint signed s;
        longint signed lo;
        longint signed hi;
        int bits;
        int sh;
        longint unsigned field;
        s = $signed(b);
        if (c[2]) begin
`ifdef IMM_ENC_MOV_EN
            int nz;
            int first;
            longint unsigned hw;
            nz = 0;
            first = -1;
            for (int k = 0; k < 4; k++) begin
                hw = (b >> (16 * k)) % 65536;
                if (hw != 0) begin
                    nz++;
                    if (first < 0) first = k;
                end
            end
            if (first < 0) begin
                imm = 26'd0;
            end else begin
                hw = (b >> (16 * first)) % 65536;
                imm = 26'(longint'(first) * (2 ** 21) + longint'(hw) * 32);
            end
            f = (nz <= 1);
            lat = 4;
`else
            imm = 26'd0;
            f = 1'b0;
            lat = 1;
`endif
        end else begin
            case (c[1:0])
                2'b00:   begin bits = 12; sh = 10; end
                2'b01:   begin bits = 9;  sh = 12; end
                2'b10:   begin bits = 26; sh = 0;  end
                default: begin bits = 19; sh = 5;  end
            endcase
            hi = (longint'(1) <<< (bits - 1)) - 1;
            lo = -(longint'(1) <<< (bits - 1));
            field = b % (longint'(1) <<< bits);
            imm = 26'(field << sh);
            f = (s >= lo) && (s <= hi);
            lat = 1;
        end
    endtask

    task automatic do_txn(input logic [2:0] c, input logic [63:0] b, input int hold,
                          output logic [25:0] oimm, output logic ofits);
        logic [25:0] eimm;
        logic ef;
        int elat;
        int k;
        ref_enc(c, b, eimm, ef, elat);
        if (!ef) model_err = (model_err == 255) ? 255 : model_err + 1;
        @(negedge i_clk);
        chk("in_ready_idle", 64'(o_in_ready), 64'd1);
        i_ctrl = c;
        i_bus_imm = b;
        i_in_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_ctrl = 3'($urandom);
        i_bus_imm = {$urandom, $urandom};
        k = 0;
        while (!o_out_valid && k < 10) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        chk("latency", 64'(k), 64'(elat));
        chk("imm26", 64'(o_imm26), 64'(eimm));
        chk("fits", 64'(o_fits), 64'(ef));
        chk("err_count", 64'(o_err_count), 64'(model_err));
        chk("in_ready_busy", 64'(o_in_ready), 64'd0);
        oimm = o_imm26;
        ofits = o_fits;
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk);
            #1;
            chk("hold_valid", 64'(o_out_valid), 64'd1);
            chk("hold_imm", 64'(o_imm26), 64'(eimm));
            chk("hold_in_ready", 64'(o_in_ready), 64'd0);
        end
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
        chk("release_valid", 64'(o_out_valid), 64'd0);
        chk("release_in_ready", 64'(o_in_ready), 64'd1);
    endtask

    function automatic logic [63:0] rand_bus();
        logic [63:0] v;
        int mode;
        int kk;
        int sel;
        logic [63:0] one;
        mode = $urandom_range(0, 3);
        one = 64'd1;
        case (mode)
            0: v = {$urandom, $urandom};
            1: v = 64'($signed({$urandom, $urandom}) >>> $urandom_range(34, 62));
            2: v = 64'($urandom_range(0, 65535)) << (16 * $urandom_range(0, 3));
            default: begin
                sel = $urandom_range(0, 3);
                kk = (sel == 0) ? 8 : (sel == 1) ? 11 : (sel == 2) ? 18 : 25;
                case ($urandom_range(0, 3))
                    0: v = (one << kk) - 64'd1;
                    1: v = one << kk;
                    2: v = -(one << kk);
                    default: v = -(one << kk) - 64'd1;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        logic [25:0] rimm;
        logic rfits;
        i_reset = 1'b1;
        i_in_valid = 1'b0;
        i_ctrl = 3'd0;
        i_bus_imm = 64'd0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_imm", 64'(o_imm26), 64'd0);
        chk("rst_fits", 64'(o_fits), 64'd0);
        chk("rst_err", 64'(o_err_count), 64'd0);
        i_reset = 1'b0;
        chk("rst_in_ready", 64'(o_in_ready), 64'd1);

        do_txn(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 0, rimm, rfits);
        chk("dir_i_imm", 64'(rimm), 64'h03FFC00);
        chk("dir_i_fits", 64'(rfits), 64'd1);

        do_txn(3'b001, 64'h100, 0, rimm, rfits);
        chk("dir_d_imm", 64'(rimm), 64'h0100000);
        chk("dir_d_fits", 64'(rfits), 64'd0);
        chk("dir_d_err", 64'(o_err_count), 64'd1);

        do_txn(3'b100, 64'h0000_1234_0000_0000, 1, rimm, rfits);
`ifdef IMM_ENC_MOV_EN
        chk("dir_mov_imm", 64'(rimm), 64'h0424680);
        chk("dir_mov_fits", 64'(rfits), 64'd1);
        do_txn(3'b111, 64'h0001_0000_0000_0001, 0, rimm, rfits);
        chk("dir_mov2_imm", 64'(rimm), 64'h0000020);
        chk("dir_mov2_fits", 64'(rfits), 64'd0);
        do_txn(3'b101, 64'h0, 0, rimm, rfits);
        chk("dir_mov0_fits", 64'(rfits), 64'd1);
`else
        chk("dir_mov_imm", 64'(rimm), 64'h0);
        chk("dir_mov_fits", 64'(rfits), 64'd0);
`endif

        do_txn(3'b010, 64'h5, 3, rimm, rfits);
        chk("dir_b_imm", 64'(rimm), 64'h0000005);

        for (int t = 0; t < 60; t++) begin
            do_txn(3'($urandom), rand_bus(), $urandom_range(0, 2), rimm, rfits);
        end

        // Reset two cycles into a MOV scan (immediately after accept when MOV is not built).
        @(negedge i_clk);
        i_ctrl = 3'b100;
        i_bus_imm = 64'h0000_1234_0000_0000;
        i_in_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
`ifdef IMM_ENC_MOV_EN
        repeat (2) begin
            @(posedge i_clk);
            #1;
            chk("scan_no_valid", 64'(o_out_valid), 64'd0);
        end
`endif
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_err = 0;
        chk("rst_mid_valid", 64'(o_out_valid), 64'd0);
        chk("rst_mid_err", 64'(o_err_count), 64'd0);
        chk("rst_mid_in_ready", 64'(o_in_ready), 64'd1);
        repeat (5) begin
            @(posedge i_clk);
            #1;
            chk("post_rst_valid", 64'(o_out_valid), 64'd0);
            chk("post_rst_err", 64'(o_err_count), 64'd0);
        end

        // Drive ErrCount into saturation.
        for (int t = 0; t < 258; t++) begin
            do_txn(3'b001, 64'h100, 0, rimm, rfits);
        end
        chk("err_saturated", 64'(o_err_count), 64'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_field_encoder.md
IMM_FIELD_ENCODER -- requirements
Module: imm_field_encoder

Interface
REQ-001 SHALL: Clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: InValid  in  1  request valid.
REQ-004 SHALL: InReady  out  1  block can accept a request.
REQ-005 SHALL: Ctrl  in  3  format: 000 I, 001 D, 010 B, 011 CB, 1xx MOV (Ctrl[1:0] ignored).
REQ-006 SHALL: BusImm  in  64  full-width immediate to compress into an instruction field.
REQ-007 SHALL: Imm26  out  26  packed immediate field, in the same bit positions the sign extender reads.
REQ-008 SHALL: Fits  out  1  BusImm is exactly representable in the chosen format.
REQ-009 SHALL: OutValid  out  1  Imm26/Fits valid.
REQ-010 SHALL: OutReady  in  1  consumer accepts the result.
REQ-011 SHALL: ErrCount  out  8  saturating count of results delivered with Fits=0.

Function
REQ-012 SHALL: FSM states are IDLE, CHECK, SCAN and DONE; InReady = (state==IDLE).
REQ-013 SHALL: accept on InValid&&InReady; capture Ctrl and BusImm; ignore later input changes until the next accept.
REQ-014 SHALL: for I/D/B/CB, go IDLE->CHECK->DONE; accepted at edge N gives OutValid=1 after edge N+1.
REQ-015 SHALL: for MOV, go IDLE->SCAN; examine one halfword per cycle (hw0..hw3) with a 2-bit counter; enter DONE after edge N+4.
REQ-016 SHALL: I: Imm26[21:10]=BusImm[11:0]; Fits iff BusImm[63:11] all equal BusImm[11].
REQ-017 SHALL: D: Imm26[20:12]=BusImm[8:0]; Fits iff BusImm[63:8] all equal BusImm[8].
REQ-018 SHALL: B: Imm26[25:0]=BusImm[25:0]; Fits iff BusImm[63:25] all equal BusImm[25].
REQ-019 SHALL: CB: Imm26[23:5]=BusImm[18:0]; Fits iff BusImm[63:18] all equal BusImm[18].
REQ-020 SHALL: MOV: Imm26[22:21]=index of lowest nonzero halfword and Imm26[20:5]=that halfword; Fits iff at most one halfword is nonzero.
REQ-021 SHALL: if all four MOV halfwords are zero, produce index 0, value 0 and Fits=1.
REQ-022 SHALL: drive all Imm26 bits not named for the format to 0.
REQ-023 SHALL: when Fits=0, still pack the truncated bits as defined above.
REQ-024 SHALL: hold Imm26, Fits and OutValid stable in DONE while OutReady=0.
REQ-025 SHALL: on DONE&&OutReady, move to IDLE; InReady rises the next cycle, with no same-cycle bypass.
REQ-026 SHALL: increment ErrCount once on each DONE entry with Fits=0, saturating at 8'hFF.

Reset
REQ-027 SHALL: when Reset=1 at an edge, set state to IDLE, Imm26=0, Fits=0, OutValid=0, ErrCount=0 and the scan counter to 0.
REQ-028 SHALL: Reset in any state, including mid-SCAN, abandons the request with no output and no ErrCount change.
REQ-029 SHALL: InReady=1 in the first cycle after Reset deasserts.

Configuration
REQ-030 SHALL: with macro IMM_ENC_MOV_EN defined, Ctrl=1xx behaves as in REQ-015/020/021.
REQ-031 SHALL: with IMM_ENC_MOV_EN undefined, omit SCAN and its counter; Ctrl=1xx goes IDLE->CHECK->DONE with Imm26=0 and Fits=0, and ErrCount increments.

Verification
REQ-032 SHALL: I, BusImm=64'hFFFF_FFFF_FFFF_FFFF -> two cycles after accept: Imm26=26'h03FFC00, Fits=1.
REQ-033 SHALL: D, BusImm=64'h100 -> Imm26=26'h0100000, Fits=0, ErrCount 0->1.
REQ-034 SHALL: MOV, BusImm=64'h0000_1234_0000_0000 -> OutValid after edge N+4, Imm26=26'h0424680, Fits=1; if IMM_ENC_MOV_EN is undefined, Imm26=0 and Fits=0 after edge N+1.
REQ-035 SHALL: MOV, BusImm=64'h0001_0000_0000_0001 -> Imm26=26'h0000020, Fits=0.
REQ-036 SHALL: B, BusImm=64'h5 with OutReady=0 for 3 cycles -> Imm26=26'h0000005 and OutValid held, InReady=0; IDLE on the cycle after OutReady=1.
REQ-037 SHALL: Reset asserted two cycles into a MOV SCAN -> OutValid never rises, ErrCount=0, and InReady=1 the cycle after Reset deasserts.
